muldiv_issue_ctrl: RTL

Issue and hazard controller in front of the MIPS mult/div/HI-LO unit. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from EX with a valid/ready handshake and launches each as a single-cycle one-hot op pulse. It tracks the unit's busy window and blocks both new operations and MFHI/MFLO reads until HI/LO are coherent. On a flush from MEM/WB it cancels any in-flight divide.

---
 rtl/muldiv_issue_ctrl_pkg.sv | 27 ++
 rtl/muldiv_issue_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared constants for the mult/div issue controller: op-bit indices, state encoding, default latencies.
package muldiv_issue_ctrl_pkg;
  localparam int OP_W     = 6;
  localparam int OP_MULT  = 0;
  localparam int OP_MULTU = 1;
  localparam int OP_DIV   = 2;
  localparam int OP_DIVU  = 3;
  localparam int OP_MTHI  = 4;
  localparam int OP_MTLO  = 5;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_FIXED  = 2'd1;
  localparam state_t ST_DIV    = 2'd2;
  localparam state_t ST_COMMIT = 2'd3;

  localparam int FIXED_LAT_DEF   = 2;
  localparam int DIV_MAX_CYC_DEF = 40;

  function automatic logic op_onehot(input logic [OP_W-1:0] op);
    return (op != '0) && ((op & (op - 1'b1)) == '0);
  endfunction

  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return op[OP_DIV] | op[OP_DIVU];
  endfunction
endpackage

// File: rtl/muldiv_issue_ctrl.sv
// Issue/hazard controller for the MIPS mult/div/HI-LO unit.
// Define MULDIV_WATCHDOG_EN to abort divides that exceed DIV_MAX_CYC cycles.
module muldiv_issue_ctrl
  import muldiv_issue_ctrl_pkg::*;
#(
  parameter int FIXED_LAT   = FIXED_LAT_DEF,
  parameter int DIV_MAX_CYC = DIV_MAX_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_src0,
  input  logic [31:0] req_src1,
  output logic        req_ready,
  input  logic        rd_valid,
  input  logic        rd_hi,
  output logic        rd_ready,
  output logic [31:0] rd_data,
  input  logic        flush,
  output logic [5:0]  u_op,
  output logic [31:0] u_in0,
  output logic [31:0] u_in1,
  input  logic        u_done,
  output logic        u_cancel,
  output logic        u_read_hi,
  input  logic [31:0] u_res,
  output logic        busy,
  output logic        wd_err
);

  if (FIXED_LAT < 1 || FIXED_LAT > 64 || DIV_MAX_CYC < 2 || DIV_MAX_CYC > 64) begin : g_bad_cfg
    $error("muldiv_issue_ctrl: FIXED_LAT must be 1..64 and DIV_MAX_CYC 2..64");
  end

  state_t     state, state_nx;
  logic [5:0] cnt, cnt_nx;
  logic       idle, fire, in_div, wd_hit;

  assign idle   = (state == ST_IDLE);
  assign in_div = (state == ST_DIV);
  // Illegal encodings are swallowed: handshake completes but nothing reaches the unit.
  assign fire   = idle && req_valid && !flush && !rst && op_onehot(req_op);

  assign req_ready = idle && !flush;
  assign rd_ready  = idle;
  assign rd_data   = u_res;
  assign u_read_hi = rd_hi;
  assign busy      = !idle;
  assign u_op      = fire ? req_op   : '0;
  assign u_in0     = fire ? req_src0 : '0;
  assign u_in1     = fire ? req_src1 : '0;

`ifdef MULDIV_WATCHDOG_EN
  // A done pulse on the final watchdog cycle still commits; flush takes priority over both.
  assign wd_hit = in_div && !flush && !u_done && (cnt == 6'(DIV_MAX_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst)         wd_err <= 1'b0;
    else if (wd_hit) wd_err <= 1'b1;
  end
`else
  assign wd_hit = 1'b0;
  assign wd_err = 1'b0;
`endif

  // The unit shares rst, so a reset mid-divide needs no cancel.
  assign u_cancel = !rst && in_div && (flush || wd_hit);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: if (fire) begin
        if (op_is_div(req_op)) begin
          state_nx = ST_DIV;
          cnt_nx   = '0;
        end else begin
          state_nx = ST_FIXED;
          cnt_nx   = 6'(FIXED_LAT - 1);
        end
      end
      ST_FIXED: begin
        if (cnt == '0) state_nx = ST_IDLE;
        else           cnt_nx   = cnt - 6'd1;
      end
      ST_DIV: begin
        if (flush || wd_hit) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else if (u_done) begin
          state_nx = ST_COMMIT;
        end else if (cnt != 6'h3f) begin
          cnt_nx   = cnt + 6'd1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

endmodule
